fetch_predictor: RTL and testbench

- Parametrised instruction-fetch front end: the program counter register, the next-PC selection and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits in the IF stage. pc_o drives instruction memory. The ID stage resolves branches and jumps, then returns updates and redirects.
- Replaces the fixed pc+4 / branch-mux / jump-mux path with speculative next-PC prediction.

---
 rtl/fetch_predictor.sv | 136 +++++++++++++
 tb/tb_fetch_predictor.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_predictor.sv
// IF-stage PC register, next-PC select and direct-mapped BTB with 2-bit counters.
// Optional stats counters when FETCH_PRED_STATS_EN is defined.
module fetch_predictor #(
  parameter int ADDR_W    = 32,
  parameter int BTB_DEPTH = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  output logic              flush_o
`ifdef FETCH_PRED_STATS_EN
  ,
  output logic [15:0]       stat_redirects_o,
  output logic [15:0]       stat_updates_o
`endif
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ADDR_W-1:0] pc_q, pc_d;

  logic              valid_q [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q   [BTB_DEPTH];
  logic [ADDR_W-1:0] tgt_q   [BTB_DEPTH];
  logic [1:0]        ctr_q   [BTB_DEPTH];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit;
  logic              we;
  logic [1:0]        ctr_d;
  logic [ADDR_W-1:0] tgt_d;
  logic              unused_lsb;

  assign unused_lsb = ^{upd_pc_i[1:0], redirect_pc_i[1:0]};

  assign lk_idx = pc_q[IDX_W+1:2];
  assign lk_tag = pc_q[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign pc_o          = pc_q;
  assign pred_taken_o  = lk_hit & ctr_q[lk_idx][1];
  assign pred_target_o = lk_hit ? tgt_q[lk_idx] : '0;
  assign flush_o       = redirect_i;

  always_comb begin
    pc_d = pc_q;
    priority case (1'b1)
      redirect_i:   pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
      stall_i:      pc_d = pc_q;
      pred_taken_o: pc_d = pred_target_o;
      default:      pc_d = pc_q + ADDR_W'(4);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Hit entries train in place; a taken miss evicts whatever lives there.
  always_comb begin
    we    = 1'b0;
    ctr_d = ctr_q[up_idx];
    tgt_d = tgt_q[up_idx];
    if (upd_valid_i) begin
      if (up_hit) begin
        we = 1'b1;
        if (upd_taken_i) begin
          ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
          tgt_d = upd_target_i;
        end else begin
          ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        end
      end else if (upd_taken_i) begin
        we    = 1'b1;
        ctr_d = 2'b10;
        tgt_d = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= tgt_d;
      ctr_q[up_idx]   <= ctr_d;
    end
  end

`ifdef FETCH_PRED_STATS_EN
  logic [15:0] redir_cnt_q, upd_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redir_cnt_q <= '0;
      upd_cnt_q   <= '0;
    end else begin
      if (redirect_i && redir_cnt_q != 16'hFFFF)
        redir_cnt_q <= redir_cnt_q + 16'd1;
      if (upd_valid_i && upd_cnt_q != 16'hFFFF)
        upd_cnt_q <= upd_cnt_q + 16'd1;
    end
  end

  assign stat_redirects_o = redir_cnt_q;
  assign stat_updates_o   = upd_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_predictor.sv
// Scoreboard bench for fetch_predictor: per-cycle expected outputs are
// queued by the driver and checked by a negedge monitor.
module tb_fetch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redir, uv, ut;
  logic [31:0] rpc, upc, utgt;
  logic [31:0] pc, ptgt;
  logic        pt, fl;
`ifdef FETCH_PRED_STATS_EN
  logic [15:0] st_r, st_u;
`endif

  fetch_predictor #(
    .ADDR_W(32),
    .BTB_DEPTH(64),
    .RESET_PC(32'h100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .stall_i(stall),
    .redirect_i(redir),
    .redirect_pc_i(rpc),
    .upd_valid_i(uv),
    .upd_pc_i(upc),
    .upd_taken_i(ut),
    .upd_target_i(utgt),
    .pc_o(pc),
    .pred_taken_o(pt),
    .pred_target_o(ptgt),
    .flush_o(fl)
`ifdef FETCH_PRED_STATS_EN
    ,
    .stat_redirects_o(st_r),
    .stat_updates_o(st_u)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (pc !== e.pc || pt !== e.pt || ptgt !== e.tgt || fl !== e.fl) begin
        bad++;
        $display("FAIL cyc%0d: got pc=%h pt=%b tgt=%h fl=%b want pc=%h pt=%b tgt=%h fl=%b",
                 e.id, pc, pt, ptgt, fl, e.pc, e.pt, e.tgt, e.fl);
      end
    end
  end

  task automatic step(
    input logic r, input logic s, input logic rd, input logic [31:0] rp,
    input logic v, input logic [31:0] up, input logic t, input logic [31:0] tg,
    input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_tg,
    input logic e_fl);
    exp_t e;
    rst = r; stall = s; redir = rd; rpc = rp;
    uv = v; upc = up; ut = t; utgt = tg;
    e.id = cyc; e.pc = e_pc; e.pt = e_pt; e.tgt = e_tg; e.fl = e_fl;
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 0; redir = 0; rpc = 0;
    uv = 0; upc = 0; ut = 0; utgt = 0;
    repeat (2) @(posedge clk);
    #1;
    //   rst stl red rpc         uv upc         t tgt          pc           pt tgt          fl
    step(1, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h100,     0, 32'h0,      0);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h100,     0, 32'h0,      0);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h104,     0, 32'h0,      0);
    step(0, 0, 0, 32'h0,        1, 32'h108,    1, 32'h200,    32'h108,     0, 32'h0,      0);
    step(0, 0, 1, 32'h108,      0, 32'h0,      0, 32'h0,      32'h10C,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h108,     1, 32'h200,    0);
    step(0, 0, 0, 32'h0,        1, 32'h108,    0, 32'h0,      32'h200,     0, 32'h0,      0);
    step(0, 0, 1, 32'h108,      1, 32'h108,    0, 32'h0,      32'h204,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        1, 32'h108,    0, 32'h0,      32'h108,     0, 32'h200,    0);
    step(0, 0, 1, 32'h108,      1, 32'h108,    1, 32'h280,    32'h10C,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h108,     0, 32'h280,    0);
    step(0, 1, 1, 32'h303,      0, 32'h0,      0, 32'h0,      32'h10C,     0, 32'h0,      1);
    step(0, 1, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h300,     0, 32'h0,      0);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h300,     0, 32'h0,      0);
    step(0, 0, 1, 32'h108,      1, 32'h208,    1, 32'h400,    32'h304,     0, 32'h0,      1);
    step(0, 0, 1, 32'h208,      0, 32'h0,      0, 32'h0,      32'h108,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h208,     1, 32'h400,    0);
    step(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,      0, 32'h0,      32'h400,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'hFFFFFFFC,0, 32'h0,      0);
    step(0, 0, 0, 32'h0,        1, 32'h20B,    1, 32'h500,    32'h0,       0, 32'h0,      0);
    step(0, 0, 1, 32'h208,      0, 32'h0,      0, 32'h0,      32'h4,       0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h208,     1, 32'h500,    0);
    // Reset lands mid-cycle on top of an in-flight taken update.
    step(1, 0, 0, 32'h0,        1, 32'h100,    1, 32'h600,    32'h100,     0, 32'h0,      0);
    step(0, 0, 1, 32'h208,      0, 32'h0,      0, 32'h0,      32'h100,     0, 32'h0,      1);
    step(0, 0, 0, 32'h0,        0, 32'h0,      0, 32'h0,      32'h208,     0, 32'h0,      0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
